// File: rtl/paralelo_serial_idle_if.sv
// Parallel-byte handshake in, serial bit stream out, for paralelo_serial_idle.
// master = upstream byte source / line monitor, slave = the serializer.
interface paralelo_serial_idle_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       sym_start;
    logic       idle_out;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out,
        input  data_out,
        input  sym_start,
        input  idle_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out,
        output data_out,
        output sym_start,
        output idle_out
    );
endinterface

// File: rtl/paralelo_serial_idle.sv
// Byte-to-serial converter, MSB first, filling empty symbol slots with idle 8'hBC.
// Optional macro IDLE_COUNT_EN adds a saturating idle-symbol counter output.
module paralelo_serial_idle (
    input  logic                 clk_32f,
    input  logic                 reset_L,
    paralelo_serial_idle_if.slave bus
`ifdef IDLE_COUNT_EN
    ,
    output logic [7:0]           idle_count
`endif
);
    localparam logic [7:0] IDLE_SYM = 8'hBC;

    typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;

    buf_state_t buf_state;
    logic [2:0] cnt;
    logic [7:0] sr;
    logic [7:0] hold_buf;
    logic       boundary;
    logic       accept;
    logic       buf_full;

    assign buf_full      = (buf_state == BUF_FULL);
    assign boundary      = (cnt == 3'd7);
    assign accept        = bus.valid_in && bus.ready_out;
    assign bus.data_out  = sr[7];
    assign bus.sym_start = (cnt == 3'd0);

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            cnt           <= '0;
            sr            <= IDLE_SYM;
            buf_state     <= BUF_EMPTY;
            hold_buf      <= '0;
            bus.ready_out <= 1'b0;
            bus.idle_out  <= 1'b1;
        end else begin
            cnt <= cnt + 3'd1;
            if (accept) begin
                hold_buf <= bus.data_in;
            end
            if (boundary) begin
                if (buf_full) begin
                    // ready_out is low here, so no accept can collide with the drain
                    sr            <= hold_buf;
                    bus.idle_out  <= 1'b0;
                    buf_state     <= BUF_EMPTY;
                    bus.ready_out <= 1'b1;
                end else begin
                    sr            <= IDLE_SYM;
                    bus.idle_out  <= 1'b1;
                    buf_state     <= accept ? BUF_FULL : BUF_EMPTY;
                    bus.ready_out <= !accept;
                end
            end else begin
                sr <= {sr[6:0], 1'b0};
                if (accept) begin
                    buf_state <= BUF_FULL;
                end
                bus.ready_out <= !(buf_full || accept);
            end
        end
    end

`ifdef IDLE_COUNT_EN
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            idle_count <= '0;
        end else if (boundary && !buf_full && (idle_count != 8'hFF)) begin
            idle_count <= idle_count + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_paralelo_serial_idle.sv
// Self-checking bench for paralelo_serial_idle: directed vector table, corner sequences,
// and randomized traffic against a symbol-level reference model and byte scoreboard.
module tb_paralelo_serial_idle;
    localparam logic [7:0] BC = 8'hBC;

    logic clk_32f = 1'b0;
    logic reset_L = 1'b0;
`ifdef IDLE_COUNT_EN
    logic [7:0] idle_count;
`endif

    paralelo_serial_idle_if ps ();

    paralelo_serial_idle dut (
        .clk_32f    (clk_32f),
        .reset_L    (reset_L),
        .bus        (ps)
`ifdef IDLE_COUNT_EN
        ,
        .idle_count (idle_count)
`endif
    );

    always #5 clk_32f = ~clk_32f;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       dout;
        logic       ss;
        logic       idle;
        logic       rdy;
    } vec_t;

    typedef struct {
        logic       idle;
        logic [7:0] b;
    } sym_t;

    // reference model: current symbol, bit phase, pending bytes
    logic [7:0] m_sym;
    logic       m_idle;
    int         m_phase;
    logic       m_ready;
    int         m_icnt;
    logic [7:0] m_pend[$];
    logic [7:0] acc_q[$];

    // line receiver
    sym_t       sym_q[$];
    logic       rx_active;
    logic [7:0] rx_bits;
    logic       rx_idle;
    int         rx_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sym   = BC;
        m_idle  = 1'b1;
        m_phase = 0;
        m_ready = 1'b0;
        m_icnt  = 0;
        m_pend.delete();
        acc_q.delete();
        sym_q.delete();
        rx_active = 1'b0;
        rx_n      = 0;
        rx_bits   = '0;
        rx_idle   = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d);
        logic acc;
        acc = v && m_ready;
        if (m_phase == 7) begin
            if (m_pend.size() > 0) begin
                m_sym  = m_pend.pop_front();
                m_idle = 1'b0;
            end else begin
                m_sym  = BC;
                m_idle = 1'b1;
                if (m_icnt < 255) m_icnt++;
            end
        end
        if (acc) begin
            m_pend.push_back(d);
            acc_q.push_back(d);
        end
        m_phase = (m_phase + 1) % 8;
        m_ready = (m_pend.size() == 0);
    endtask

    task automatic model_check();
        check("m_data_out", ps.data_out, m_sym[7 - m_phase]);
        check("m_sym_start", ps.sym_start, (m_phase == 0));
        check("m_idle_out", ps.idle_out, m_idle);
        check("m_ready_out", ps.ready_out, m_ready);
`ifdef IDLE_COUNT_EN
        check("m_idle_count", idle_count, m_icnt);
`endif
    endtask

    task automatic rx_sample();
        if (ps.sym_start) begin
            rx_active = 1'b1;
            rx_n      = 0;
            rx_bits   = '0;
            rx_idle   = ps.idle_out;
        end
        if (rx_active) begin
            rx_bits = {rx_bits[6:0], ps.data_out};
            rx_n++;
            if (rx_n == 8) begin
                sym_q.push_back('{rx_idle, rx_bits});
                rx_active = 1'b0;
            end
        end
    endtask

    // called at a negedge: drive, clock, model, then sample at the next negedge
    task automatic cycle(input logic v, input logic [7:0] d);
        ps.valid_in = v;
        ps.data_in  = d;
        @(posedge clk_32f);
        model_edge(v, d);
        @(negedge clk_32f);
        model_check();
        rx_sample();
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        ps.valid_in = 1'b0;
        ps.data_in  = '0;
        @(negedge clk_32f);
        @(negedge clk_32f);
        check("rst_data_out", ps.data_out, 1'b1);
        check("rst_sym_start", ps.sym_start, 1'b1);
        check("rst_ready_out", ps.ready_out, 1'b0);
        check("rst_idle_out", ps.idle_out, 1'b1);
`ifdef IDLE_COUNT_EN
        check("rst_idle_count", idle_count, 8'd0);
`endif
        model_reset();
        reset_L = 1'b1;
    endtask

    vec_t vecs[25];

    initial begin
        logic [7:0] seq[3];
        int         idx;
        int         first;
        int         nonidle;
        logic       rdy;
        logic       found;
        logic [7:0] rx_data[$];

        ps.valid_in = 1'b0;
        ps.data_in  = '0;
        model_reset();

        // directed table: idle pattern, FF accepted, valid held while not ready
        vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 8'h34, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 8'h56, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 8'h78, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 8'h9A, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[22] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[23] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[24] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};

        @(negedge clk_32f);
        do_reset();
        for (int i = 0; i < 25; i++) begin
            cycle(vecs[i].v, vecs[i].d);
            check($sformatf("vec%0d_data_out", i), ps.data_out, vecs[i].dout);
            check($sformatf("vec%0d_sym_start", i), ps.sym_start, vecs[i].ss);
            check($sformatf("vec%0d_idle_out", i), ps.idle_out, vecs[i].idle);
            check($sformatf("vec%0d_ready_out", i), ps.ready_out, vecs[i].rdy);
        end

        // back-to-back FF, EE, BC with valid offered whenever ready is high
        do_reset();
        seq[0] = 8'hFF;
        seq[1] = 8'hEE;
        seq[2] = 8'hBC;
        idx = 0;
        for (int c = 0; c < 48; c++) begin
            if (idx < 3) begin
                rdy = ps.ready_out;
                cycle(1'b1, seq[idx]);
                if (rdy) idx++;
            end else begin
                cycle(1'b0, 8'h00);
            end
        end
        check("b2b_all_offered", idx, 3);
        first = -1;
        foreach (sym_q[i]) if (first < 0 && !sym_q[i].idle) first = i;
        check("b2b_data_seen", (first >= 0), 1'b1);
        if (first >= 0 && sym_q.size() >= first + 3) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("b2b_sym%0d_idle", k), sym_q[first + k].idle, 1'b0);
                check($sformatf("b2b_sym%0d_byte", k), sym_q[first + k].b, seq[k]);
            end
        end else begin
            check("b2b_sym_count", sym_q.size(), first + 3);
        end

        // reset pulled asynchronously at bit 3 of a data symbol
        do_reset();
        cycle(1'b0, 8'h00);
        cycle(1'b1, 8'hA5);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            cycle(1'b0, 8'h00);
            if (ps.sym_start && !ps.idle_out) found = 1'b1;
        end
        check("arst_data_sym_seen", found, 1'b1);
        for (int c = 0; c < 3; c++) cycle(1'b0, 8'h00);
        check("arst_mid_data_out", ps.data_out, 1'b0);
        #2 reset_L = 1'b0;
        #1;
        check("arst_data_out", ps.data_out, 1'b1);
        check("arst_ready_out", ps.ready_out, 1'b0);
        check("arst_sym_start", ps.sym_start, 1'b1);
        check("arst_idle_out", ps.idle_out, 1'b1);
        @(negedge clk_32f);
        model_reset();
        reset_L = 1'b1;
        for (int c = 0; c < 24; c++) cycle(1'b0, 8'h00);
        nonidle = 0;
        foreach (sym_q[i]) if (!sym_q[i].idle) nonidle++;
        check("arst_no_data_after", nonidle, 0);

        // randomized traffic, valid frequently held while not ready
        do_reset();
        for (int c = 0; c < 1200; c++) begin
            logic       v;
            logic [7:0] d;
            v = (($urandom % 4) != 0);
            d = (($urandom % 4) == 0) ? BC : 8'($urandom);
            cycle(v, d);
        end
        for (int c = 0; c < 24; c++) cycle(1'b0, 8'h00);
        rx_data.delete();
        foreach (sym_q[i]) if (!sym_q[i].idle) rx_data.push_back(sym_q[i].b);
        check("rnd_byte_count", rx_data.size(), acc_q.size());
        check("rnd_some_traffic", (acc_q.size() > 50), 1'b1);
        for (int i = 0; i < acc_q.size() && i < rx_data.size(); i++) begin
            check($sformatf("rnd_byte%0d", i), rx_data[i], acc_q[i]);
        end

`ifdef IDLE_COUNT_EN
        do_reset();
        for (int c = 0; c < 2400; c++) cycle(1'b0, 8'h00);
        check("icnt_saturated", idle_count, 8'd255);
        cycle(1'b1, 8'h3C);
        for (int c = 0; c < 24; c++) cycle(1'b0, 8'h00);
        check("icnt_after_byte", idle_count, 8'd255);
        #2 reset_L = 1'b0;
        #1;
        check("icnt_reset", idle_count, 8'd0);
        @(negedge clk_32f);
        model_reset();
        reset_L = 1'b1;
        for (int c = 0; c < 16; c++) cycle(1'b0, 8'h00);
        check("icnt_after_reset", idle_count, 8'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
